// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the execute-stage ALU.
// It captures one decoded instruction per cycle and resolves the ALU operands
// through EX/MEM and MEM/WB forwarding. It also raises load-use and inserts a
// bubble, and it obeys hold and flush.
module id_ex_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rt,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [1:0]  id_alu_src,
  input  logic [3:0]  id_aluop,
  input  logic        id_regwen,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        exmem_regwen,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwen,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  input  logic        hold,
  input  logic        flush,
  output logic        load_use,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  OPCODE,
  output logic        ex_valid,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_regwen,
  output logic        ex_memread,
  output logic        ex_memwrite
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [1:0]  alu_src;
    logic [3:0]  aluop;
    logic        regwen;
    logic        memread;
    logic        memwrite;
  } ex_slot_t;

  ex_slot_t slot_q, slot_d, id_slot;
  logic [31:0] fwd_rs, fwd_rt;

  // EX/MEM has priority over MEM/WB. Register 0 is hardwired and never forwarded.
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] stored,
                                      input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                                      input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    if (ew && erd != 5'd0 && erd == r)      return eres;
    else if (mw && mrd != 5'd0 && mrd == r) return mres;
    else                                    return stored;
  endfunction

  // Pack the decode-slot inputs so that a normal load is a single assignment.
  always_comb begin
    id_slot          = '0;
    id_slot.valid    = id_valid;
    id_slot.rs       = id_rs;
    id_slot.rt       = id_rt;
    id_slot.rd       = id_rd;
    id_slot.rs_data  = id_rs_data;
    id_slot.rt_data  = id_rt_data;
    id_slot.imm      = id_imm;
    id_slot.shamt    = id_shamt;
    id_slot.alu_src  = id_alu_src;
    id_slot.aluop    = id_aluop;
    id_slot.regwen   = id_regwen;
    id_slot.memread  = id_memread;
    id_slot.memwrite = id_memwrite;
  end

  // Detect a load in EX whose destination feeds the instruction now in decode.
  always_comb begin
    load_use = id_valid & slot_q.valid & slot_q.memread & (slot_q.rd != 5'd0) &
               ((slot_q.rd == id_rs) | (id_uses_rt & (slot_q.rd == id_rt)));
  end

  // Next-state priority is flush, then hold, then bubble, then normal load.
  // A bubble or flush clears every field, so a squashed slot is all zeros.
  always_comb begin
    slot_d = slot_q;
    if (flush)         slot_d = '0;
    else if (hold)     slot_d = slot_q;
    else if (load_use) slot_d = '0;
    else               slot_d = id_slot;
  end

  // Synchronous reset overrides every other event.
  always_ff @(posedge CLK) begin
    if (RST) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  // Resolve operands through forwarding, then pick the A/B sources by alu_src.
  // Code 11 behaves the same as 00.
  always_comb begin
    fwd_rs = fwd(slot_q.rs, slot_q.rs_data, exmem_regwen, exmem_rd, exmem_result,
                 memwb_regwen, memwb_rd, memwb_result);
    fwd_rt = fwd(slot_q.rt, slot_q.rt_data, exmem_regwen, exmem_rd, exmem_result,
                 memwb_regwen, memwb_rd, memwb_result);
    A = fwd_rs;
    B = fwd_rt;
    case (slot_q.alu_src)
      2'b01:   begin A = fwd_rs; B = slot_q.imm;                end
      2'b10:   begin A = fwd_rt; B = {27'b0, slot_q.shamt};     end
      default: begin A = fwd_rs; B = fwd_rt;                    end
    endcase
  end

  // Downstream controls are forced low whenever the slot holds no instruction.
  always_comb begin
    OPCODE        = slot_q.aluop;
    ex_valid      = slot_q.valid;
    ex_rd         = slot_q.rd;
    ex_store_data = fwd_rt;
    ex_regwen     = slot_q.valid & slot_q.regwen;
    ex_memread    = slot_q.valid & slot_q.memread;
    ex_memwrite   = slot_q.valid & slot_q.memwrite;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that feeds the execute-stage ALU. Each cycle it captures one decoded instruction (operand values, register numbers, immediate, ALU opcode, memory/writeback controls) and presents fully resolved 32-bit operands A/B plus the 4-bit ALU opcode to the ALU. Operands are forwarded from the EX/MEM and MEM/WB stages. The stage also detects load-use hazards, inserts bubbles, and honours pipeline hold and flush.

## Interface
- No parameters. Data 32 bits, register numbers 5 bits, opcode 4 bits.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs, id_rt, id_rd  in  5 each  source/destination register numbers.
- id_uses_rt  in  1  instruction reads rt (hazard check only).
- id_rs_data, id_rt_data  in  32 each  register-file read data.
- id_imm  in  32  extended immediate.
- id_shamt  in  5  shift amount.
- id_alu_src  in  2  00 A=rs,B=rt; 01 A=rs,B=imm; 10 A=rt,B={27'b0,shamt}; 11 treated as 00.
- id_aluop  in  4  ALU opcode (0 sll … 9 sltu).
- id_regwen, id_memread, id_memwrite  in  1 each  downstream controls.
- exmem_regwen, exmem_rd, exmem_result  in  1/5/32  EX/MEM forwarding source.
- memwb_regwen, memwb_rd, memwb_result  in  1/5/32  MEM/WB forwarding source.
- hold  in  1  freeze stage contents.
- flush  in  1  squash stage contents.
- load_use  out  1  combinational; decode must hold IF/ID this cycle.
- A, B  out  32 each  ALU operands.
- OPCODE  out  4  ALU opcode.
- ex_valid  out  1  EX slot valid.
- ex_store_data  out  32  forwarded rt value for stores.
- ex_rd  out  5  destination register.
- ex_regwen, ex_memread, ex_memwrite  out  1 each  gated by ex_valid (0 when invalid).

## Operation
- Stored registers: valid, rs, rt, rd, rs_data, rt_data, imm, shamt, alu_src, aluop, regwen, memread, memwrite.
- Update priority on each edge: RST > flush > hold > load_use > normal load.
  - RST: all stored registers cleared to 0.
  - flush: valid←0 and controls←0. Data fields are don't-care; they are cleared to 0.
  - hold: all registers keep their value. Takes precedence over load_use.
  - load_use: bubble loaded (valid←0, controls←0).
  - normal: all id_* fields captured, valid←id_valid.
- load_use = id_valid & ex_valid & ex_memread & (ex_rd≠0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- Forwarding is combinational on the stored rs/rt (fwd_rs, fwd_rt):
  - EX/MEM match (exmem_regwen & exmem_rd≠0 & exmem_rd==reg) → exmem_result.
  - Else MEM/WB match under the same rule → memwb_result.
  - Else stored data.
  - Register 0 is never forwarded; EX/MEM wins over MEM/WB.
- Operand select by stored alu_src:
  - 00/11: A=fwd_rs, B=fwd_rt.
  - 01: A=fwd_rs, B=imm.
  - 10: A=fwd_rt, B={27'b0,shamt}.
- OPCODE = stored aluop. ex_store_data = fwd_rt.
- While ex_valid=0, A/B/OPCODE still reflect the stored fields and are don't-care downstream. All ex_* controls are forced 0.

## Timing
- Latency: instruction on id_* at edge N appears on A/B/OPCODE/ex_* after edge N (one cycle).
- Forwarding and load_use are same-cycle combinational, with no added latency. A forwarding source changing mid-cycle updates A/B within the same cycle, including while hold=1.
- Reset values after an RST edge: ex_valid=0, ex_rd=0, ex_regwen/ex_memread/ex_memwrite=0, A=0, B=0, OPCODE=0, ex_store_data=0, load_use=0. This assumes the forwarding inputs are not matching register 0, which they never do.
- Simultaneous events:
  - flush+hold: flush wins.
  - flush+load_use: flush wins (bubble either way).
  - hold+load_use: contents frozen. load_use stays asserted and re-evaluates after release.
- RST during hold/flush: reset wins. The stage is empty on the next cycle.
- A load followed by a dependent instruction gives exactly one bubble. The instruction then resolves its operand through MEM/WB forwarding.

## Test plan
- Reset: assert RST for 2 cycles with id_valid=1 → ex_valid=0, A=B=0, OPCODE=0, all controls 0. First load after release appears one cycle later.
- Plain ALU op: id_rs_data=5, id_rt_data=3, aluop=6, alu_src=00 → next cycle A=5, B=3, OPCODE=6. Then alu_src=01 with imm=0xFFFF_FFFC gives B=0xFFFF_FFFC.
- Forward priority: stored rs=8. exmem(regwen=1, rd=8, 0x11) and memwb(regwen=1, rd=8, 0x22) → A=0x11. Drop exmem_regwen → A=0x22. Set rs=0 with rd=0 sources at 0x33 → A=stored rs_data.
- Load-use: EX holds lw (memread=1, rd=9), decode has add rs=9 → load_use=1 and next cycle ex_valid=0. Following cycle the add enters and memwb(rd=9, 0x44) gives A=0x44.
- Shift select: alu_src=10, id_rt_data=1, shamt=4, aluop=0 → A=1, B=4. Set exmem rd=rt with 0x80 → A=0x80.
- Hold/flush: hold=1 for 3 cycles with changing id_* → outputs unchanged. hold=1 with flush=1 → ex_valid=0 and controls 0 next cycle.
